// File: rtl/upscaler_pkg.sv
// rtl/upscaler_pkg.sv - shared widths, bicubic coefficient table and FSM encoding for the upscaler
//
// Purpose: constants shared by the horizontal bicubic interpolator and its
//   coefficient ROM.
// Contents: pixel/coefficient/accumulator widths, the Q7 bicubic weight
//   table (a = -0.5, each row sums to 128), and the MAC sequencer states.
package upscaler_pkg;

  localparam int PIX_W   = 8;
  localparam int COEF_W  = 9;
  localparam int ACC_W   = 20;
  localparam int PHASES  = 4;
  localparam int TAPS    = 4;
  localparam int PHASE_W = 2;
  localparam int TAP_W   = 2;
  // Zero-extended pixel times signed coefficient always fits this width.
  localparam int PROD_W  = PIX_W + COEF_W;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  // Row = phase, column = tap (pixels x-1, x, x+1, x+2).
  localparam coef_t BICUBIC_COEF [PHASES][TAPS] = '{
    '{coef_t'(0),  coef_t'(128), coef_t'(0),   coef_t'(0)},
    '{coef_t'(-9), coef_t'(111), coef_t'(29),  coef_t'(-3)},
    '{coef_t'(-8), coef_t'(72),  coef_t'(72),  coef_t'(-8)},
    '{coef_t'(-3), coef_t'(29),  coef_t'(111), coef_t'(-9)}
  };

endpackage

// File: rtl/bicubic_coeff_rom.sv
// rtl/bicubic_coeff_rom.sv - combinational phase/tap to Q7 bicubic coefficient lookup
//
// Purpose: selects one signed Q7 weight from the bicubic table.
// Ports:
//   phase  in   PHASE_W  sub-pixel phase; values >= PHASES fall back to phase 0
//   tap    in   TAP_W    tap index 0..3
//   coef   out  COEF_W   signed Q7 coefficient
module bicubic_coeff_rom
  import upscaler_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  input  logic [TAP_W-1:0]   tap,
  output coef_t              coef
);

  always_comb begin
    coef = BICUBIC_COEF[0][tap];
    if (int'(phase) < PHASES) begin
      coef = BICUBIC_COEF[phase][tap];
    end
  end

endmodule

// File: rtl/bicubic_tap_mac.sv
// rtl/bicubic_tap_mac.sv - 4-tap horizontal bicubic MAC with one shared multiplier
//
// Purpose: weighted sum of four neighbouring pixels in Q7, one tap per cycle,
//   feeding the pixel clipper.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   in_valid / in_ready    upstream handshake for one pixel group + phase
//   in_p0..in_p3           unsigned pixels x-1, x, x+1, x+2
//   in_phase               sub-pixel phase
//   out_valid / out_ready  downstream handshake
//   out_sum                signed Q7 weighted sum
module bicubic_tap_mac
  import upscaler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_p0,
  input  logic [PIX_W-1:0]         in_p1,
  input  logic [PIX_W-1:0]         in_p2,
  input  logic [PIX_W-1:0]         in_p3,
  input  logic [PHASE_W-1:0]       in_phase,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum
);

  mac_state_t state, state_nxt;

  logic [PIX_W-1:0]         pix_q [TAPS];
  logic [PHASE_W-1:0]       phase_q;
  logic [TAP_W-1:0]         tap;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept;
  logic                     last_tap;
  coef_t                    coef;
  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;

  assign accept   = in_valid & in_ready;
  assign last_tap = (tap == TAP_W'(TAPS - 1));

  bicubic_coeff_rom u_coeff_rom (
    .phase (phase_q),
    .tap   (tap),
    .coef  (coef)
  );

  // Pixels are unsigned: a zero MSB keeps them positive in the signed multiply.
  // Both operands and the product are sign-extended, never truncated.
  always_comb begin
    pix_ext  = PROD_W'($signed({1'b0, pix_q[tap]}));
    coef_ext = PROD_W'(coef);
    prod     = pix_ext * coef_ext;
    acc_sum  = acc + ACC_W'(prod);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a DONE handoff with a waiting group goes straight to MAC
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MAC;
      MAC:  if (last_tap) state_nxt = DONE;
      DONE: begin
        if (accept) begin
          state_nxt = MAC;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    out_valid = (state == DONE);
  end

  // Datapath: capture on accept, accumulate one tap per MAC cycle,
  // publish the final sum only on the transition into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) pix_q[i] <= '0;
      phase_q <= '0;
      tap     <= '0;
      acc     <= '0;
      out_sum <= '0;
    end else if (accept) begin
      pix_q[0] <= in_p0;
      pix_q[1] <= in_p1;
      pix_q[2] <= in_p2;
      pix_q[3] <= in_p3;
      phase_q  <= in_phase;
      tap      <= '0;
      acc      <= '0;
    end else if (state == MAC) begin
      acc <= acc_sum;
      tap <= tap + TAP_W'(1);
      if (last_tap) begin
        out_sum <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_tap_mac.sv
// tb/tb_bicubic_tap_mac.sv - table-driven and directed self-checking bench for bicubic_tap_mac
module tb_bicubic_tap_mac;
  import upscaler_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [PIX_W-1:0]        in_p0, in_p1, in_p2, in_p3;
  logic [PHASE_W-1:0]      in_phase;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] p0, p1, p2, p3;
    logic [1:0] ph;
    int         exp_sum;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  bicubic_tap_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p0     (in_p0),
    .in_p1     (in_p1),
    .in_p2     (in_p2),
    .in_p3     (in_p3),
    .in_phase  (in_phase),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [7:0] a, b, c, d, input logic [1:0] ph);
    in_p0 = a; in_p1 = b; in_p2 = c; in_p3 = d; in_phase = ph;
  endtask

  // Presents a group, waits for accept, returns cycles from accept to out_valid.
  task automatic send_group(input logic [7:0] a, b, c, d, input logic [1:0] ph,
                            output int lat);
    int guard;
    guard = 0;
    set_group(a, b, c, d, ph);
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_handoff", int'(out_valid), 0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{8'd10,  8'd20,  8'd30,  8'd40,  2'd0, 2560};
    vecs[1] = '{8'd0,   8'd255, 8'd255, 8'd0,   2'd2, 36720};
    vecs[2] = '{8'd255, 8'd0,   8'd0,   8'd255, 2'd1, -3060};
    vecs[3] = '{8'd10,  8'd20,  8'd30,  8'd40,  2'd1, 2880};
    vecs[4] = '{8'd10,  8'd20,  8'd30,  8'd40,  2'd3, 3520};
    vecs[5] = '{8'd100, 8'd50,  8'd50,  8'd100, 2'd2, 5600};
    vecs[6] = '{8'd0,   8'd255, 8'd0,   8'd0,   2'd1, 28305};
    vecs[7] = '{8'd255, 8'd255, 8'd255, 8'd255, 2'd3, 32640};
    vecs[8] = '{8'd7,   8'd0,   8'd0,   8'd9,   2'd3, -102};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_group(8'd0, 8'd0, 8'd0, 8'd0, 2'd0);
    tick(); tick();
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sum", int'(out_sum), 0);
    #3 rst = 1'b0;
    tick();

    // Table-driven functional vectors
    for (int i = 0; i < 9; i++) begin
      send_group(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].ph, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), int'(out_sum), vecs[i].exp_sum);
      handshake();
    end
    check("neg_sum_raw_bits", int'({12'd0, 20'hFF40C}), 32'h000FF40C);

    // Backpressure: output held stable, no new accept, single handoff
    send_group(8'd0, 8'd255, 8'd255, 8'd0, 2'd2, lat);
    check("bp_latency", lat, 4);
    for (int c = 0; c < 10; c++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_sum", int'(out_sum), 36720);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    handshake();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_no_second_handoff", int'(out_valid), 0);
    end
    check("bp_sum_kept_after_handoff", int'(out_sum), 36720);

    // Back-to-back: B accepted on A's handoff edge
    out_ready = 1'b1;
    set_group(8'd10, 8'd20, 8'd30, 8'd40, 2'd0);
    in_valid = 1'b1;
    tick();
    set_group(8'd255, 8'd0, 8'd0, 8'd255, 2'd1);
    lat = 0;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check("b2b_a_latency", lat, 4);
    check("b2b_a_sum", int'(out_sum), 2560);
    check("b2b_in_ready_at_handoff", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("b2b_out_valid_drop", int'(out_valid), 0);
    check("b2b_in_ready_in_mac", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check("b2b_b_latency", lat, 4);
    check("b2b_b_sum", int'(out_sum), -3060);
    tick();
    out_ready = 1'b0;
    check("b2b_idle_after", int'(out_valid), 0);

    // Reset mid-MAC at tap 2
    set_group(8'd255, 8'd255, 8'd255, 8'd255, 2'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_sum", int'(out_sum), 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("midrst_no_residue_valid", int'(out_valid), 0);
    send_group(8'd10, 8'd20, 8'd30, 8'd40, 2'd2, lat);
    check("midrst_next_latency", lat, 4);
    check("midrst_next_sum", int'(out_sum), 3200);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
